switch_debounce: RTL
====================

Name: switch_debounce

Overview:
Upstream conditioning stage for the 4-bit slide-switch bus that feeds the seven-segment decoder. Each raw switch bit is synchronised, then debounced by a per-bit stability counter. The block outputs a clean, glitch-free switch value plus one-cycle rise/fall/change strobes. The display path consumes sw_stable in place of raw pins; the strobes serve control logic that reacts to switch edits.

Parameters:
WIDTH, 4, number of switch bits
SYNC_STAGES, 2, synchroniser flop depth per bit (>=2)
DB_CYCLES, 1000000, consecutive stable clk cycles required to accept a new level (10 ms at 100 MHz); >=1
CNT_W, 20, per-bit counter width; must satisfy 2^CNT_W > DB_CYCLES-1

Ports:
clk  input  1  system clock (100 MHz)
rst  input  1  synchronous reset, active-high
sw_raw  input  WIDTH  asynchronous raw switch pins
sw_stable  output  WIDTH  debounced switch value, registered
sw_rise  output  WIDTH  1-cycle pulse per bit on accepted 0->1
sw_fall  output  WIDTH  1-cycle pulse per bit on accepted 1->0
sw_changed  output  1  1-cycle pulse when any bit of sw_stable changes (OR of sw_rise|sw_fall)

Behaviour:
- Clock clk; reset rst is synchronous, active-high.
- Reset values: all synchroniser flops 0, all counters 0, sw_stable 0, sw_rise 0, sw_fall 0, sw_changed 0. Reset overrides all other activity and abandons any partial count.
- Synchroniser: sw_raw[i] passes through an SYNC_STAGES-deep flop chain. s[i] is the last stage.
- Per-bit counter cnt[i], evaluated every rising edge (bits fully independent):
  - s[i] == sw_stable[i]: cnt[i] <= 0, no output change.
  - s[i] != sw_stable[i] and cnt[i] < DB_CYCLES-1: cnt[i] <= cnt[i]+1.
  - s[i] != sw_stable[i] and cnt[i] == DB_CYCLES-1: sw_stable[i] <= s[i], cnt[i] <= 0. On the same edge, sw_rise[i] <= s[i] and sw_fall[i] <= ~s[i].
  - Otherwise sw_rise[i] and sw_fall[i] <= 0.
- sw_changed is registered on the same edge as the rise/fall pulses: it is the OR of all bits' update conditions. It is never delayed relative to them.
- Latency: sw_raw changes and is first sampled at edge k. sw_stable and the pulses update at edge k+SYNC_STAGES+DB_CYCLES-1, provided s[i] holds the new level throughout.
- Glitch rejection: any return of s[i] to sw_stable[i] before the count completes clears cnt[i]. The next change restarts the count from 0. No partial credit is kept.
- DB_CYCLES=1 case: update occurs on the first edge at which s[i] differs.
- The counter never exceeds DB_CYCLES-1, so there is no wrap-around.
- Pulse width is exactly 1 cycle. Back-to-back pulses on the same bit are impossible, since the minimum spacing is DB_CYCLES cycles.
- Simultaneous updates on several bits produce a single sw_changed pulse, with all affected rise/fall bits set in that cycle.
- After reset release with non-zero sw_raw, the block debounces from 0 normally. Rise pulses appear for the set bits.

Test Plan:
(all scenarios use DB_CYCLES=8, SYNC_STAGES=2; edge 0 = first edge sampling the new sw_raw)
1. Hold rst with sw_raw=4'b1010, then release with sw_raw held (edge 0 = first edge after release) -> outputs 0 during reset; at edge 9 sw_stable=1010, sw_rise=1010 for 1 cycle, sw_changed=1 for 1 cycle, sw_fall=0.
2. From stable 0000, sw_raw[0] high for exactly 7 cycles then low -> sw_stable stays 0000, no pulses. Repeat with 8 cycles -> sw_stable[0]=1 at edge 9, single sw_rise[0] pulse; later sw_fall[0] pulse after the low level has been held 8 cycles.
3. Bounce: sw_raw[3] toggles every 3 cycles for 30 cycles, then holds 1 -> exactly one sw_rise=1000 pulse, 9 edges after the final toggle is first sampled; no sw_fall pulses.
4. From sw_stable=0100, set sw_raw=0010 in one cycle -> on the same cycle sw_rise=0010, sw_fall=0100, sw_changed=1 (one pulse); sw_stable=0010.
5. Reset mid-operation: during a bit-1 transition, assert rst for 1 cycle when cnt=5, keeping sw_raw[1]=1 -> sw_stable stays 0; the update occurs a full 9 edges after the first post-reset sample; exactly one pulse.
6. Steady input 1111 held for 1000 cycles after acceptance -> sw_stable=1111 constant; sw_rise, sw_fall and sw_changed remain 0 throughout.

Source files
------------

// File: rtl/switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
//
// Conditions the raw slide-switch bus before it reaches the seven-segment
// decoder. Each bit is synchronised through a SYNC_STAGES-deep flop chain.
// A per-bit stability counter then debounces it: a new level is accepted only
// after the synchronised bit has differed from the current stable value for
// DB_CYCLES consecutive clock edges. Alongside the clean value, the block
// emits one-cycle rise/fall strobes per bit and a global change strobe.
//
// Ports:
//   clk         in   1      system clock (100 MHz)
//   rst         in   1      synchronous reset, active-high
//   sw_raw      in   WIDTH  asynchronous raw switch pins
//   sw_stable   out  WIDTH  debounced switch value, registered
//   sw_rise     out  WIDTH  1-cycle pulse per bit on accepted 0->1
//   sw_fall     out  WIDTH  1-cycle pulse per bit on accepted 1->0
//   sw_changed  out  1      1-cycle pulse when any bit of sw_stable changes
//
// Parameters:
//   WIDTH        number of switch bits
//   SYNC_STAGES  synchroniser depth per bit (>= 2)
//   DB_CYCLES    consecutive stable cycles needed to accept a level (>= 1)
//   CNT_W        counter width; 2**CNT_W must exceed DB_CYCLES-1
// -----------------------------------------------------------------------------
module switch_debounce #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 1000000,
  parameter int CNT_W       = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  // Terminal count: the edge on which the counter sits here while the input
  // still differs is the edge that accepts the new level.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [CNT_W-1:0] cnt_q  [WIDTH];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] differ;
  logic [WIDTH-1:0] hit;

  assign s      = sync_q[SYNC_STAGES-1];
  assign differ = s ^ sw_stable;

  // ---------------------------------------------------------------------------
  // Synchroniser chain. Stage 0 is the only flop that sees the asynchronous
  // pins; everything downstream uses the last stage.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours, which is what makes a shift chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < SYNC_STAGES; j++) begin
        sync_q[j] <= '0;
      end
    end else begin
      sync_q[0] <= sw_raw;
      for (int j = 1; j < SYNC_STAGES; j++) begin
        sync_q[j] <= sync_q[j-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Accept condition per bit: input still differs and the count is complete.
  // ---------------------------------------------------------------------------
  // NOTE: hit gets a full default before the loop so no path leaves a bit
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    hit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      hit[i] = differ[i] && (cnt_q[i] == CNT_MAX);
    end
  end

  // ---------------------------------------------------------------------------
  // Stability counters. Any cycle where the synchronised bit matches the
  // stable value throws the partial count away, so a bounce restarts from 0.
  // ---------------------------------------------------------------------------
  // NOTE: the counter array is a small register file, not RAM, and it is
  // cleared on reset so that a reset abandons any count in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!differ[i] || hit[i]) begin
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs. The strobes are registered on the same edge that updates
  // sw_stable, so a consumer sees the pulse and the new value together.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_stable  <= '0;
      sw_rise    <= '0;
      sw_fall    <= '0;
      sw_changed <= 1'b0;
    end else begin
      sw_stable  <= (sw_stable & ~hit) | (s & hit);
      sw_rise    <= hit & s;
      sw_fall    <= hit & ~s;
      sw_changed <= |hit;
    end
  end

endmodule
